// File: rtl/dsp_mac_pipelined.sv
// Parametrised multiply / multiply-accumulate / add DSP tile with an optional input register,
// 0..3 multiplier pipeline registers, an accumulator stage and an optional output register.
module dsp_mac_pipelined #(
  parameter int A_WIDTH     = 8,
  parameter int B_WIDTH     = 8,
  parameter int ACC_WIDTH   = 20,
  parameter int IN_REG      = 1,
  parameter int PIPE_STAGES = 1,
  parameter int OUT_REG     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  input  logic [1:0]           mode,
  output logic [ACC_WIDTH-1:0] out,
  output logic                 out_valid,
  output logic                 overflow
);

  // Flow control: in_valid qualifies a/b/mode on every ce-enabled edge. There is no ready;
  // one op per enabled cycle is always accepted and out_valid pulses once per op.
  localparam logic [1:0] MODE_MUL  = 2'b00;
  localparam logic [1:0] MODE_MAC  = 2'b01;
  localparam logic [1:0] MODE_ADD  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam int IW = A_WIDTH + B_WIDTH + 3;
  localparam int PW = ACC_WIDTH + 3;

  // Stage 0 word: {valid, mode, b, a}
  logic [IW-1:0] s0_d;
  logic [IW-1:0] s0;

  assign s0_d = {in_valid, mode, b, a};

  generate
    if (IN_REG != 0) begin : g_in_reg
      logic [IW-1:0] s0_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     s0_q <= '0;
        else if (ce) s0_q <= s0_d;
      end
      assign s0 = s0_q;
    end else begin : g_in_bypass
      assign s0 = s0_d;
    end
  endgenerate

  logic [A_WIDTH-1:0]   s0_a;
  logic [B_WIDTH-1:0]   s0_b;
  logic [1:0]           s0_mode;
  logic                 s0_valid;
  logic [ACC_WIDTH-1:0] s0_r;

  assign s0_a     = s0[A_WIDTH-1:0];
  assign s0_b     = s0[A_WIDTH+B_WIDTH-1:A_WIDTH];
  assign s0_mode  = s0[IW-2 -: 2];
  assign s0_valid = s0[IW-1];

  // ACC_WIDTH >= A_WIDTH+B_WIDTH, so both the product and the sum are exact here.
  always_comb begin
    if (s0_mode == MODE_ADD) s0_r = ACC_WIDTH'(s0_a) + ACC_WIDTH'(s0_b);
    else                     s0_r = ACC_WIDTH'(s0_a) * ACC_WIDTH'(s0_b);
  end

  // Pipeline word: {valid, mode, r}; st[0] is combinational, st[i+1] is register i.
  logic [PW-1:0] st [PIPE_STAGES+1];

  assign st[0] = {s0_valid, s0_mode, s0_r};

  generate
    for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_pipe
      logic [PW-1:0] st_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     st_q <= '0;
        else if (ce) st_q <= st[i];
      end
      assign st[i+1] = st_q;
    end
  endgenerate

  logic                 acc_in_valid;
  logic [1:0]           acc_in_mode;
  logic [ACC_WIDTH-1:0] acc_in_r;

  assign {acc_in_valid, acc_in_mode, acc_in_r} = st[PIPE_STAGES];

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 accv_q, accv_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH:0]   mac_sum;

  assign mac_sum = {1'b0, acc_q} + {1'b0, acc_in_r};

  // Bubbles hold acc and overflow; only the valid bit advances.
  always_comb begin
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    accv_d = acc_in_valid;
    if (acc_in_valid) begin
      case (acc_in_mode)
        MODE_MUL, MODE_ADD: acc_d = acc_in_r;
        MODE_MAC: begin
          acc_d = mac_sum[ACC_WIDTH-1:0];
          ovf_d = ovf_q | mac_sum[ACC_WIDTH];
        end
        MODE_LOAD: begin
          acc_d = acc_in_r;
          ovf_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      accv_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (ce) begin
      acc_q  <= acc_d;
      accv_q <= accv_d;
      ovf_q  <= ovf_d;
    end
  end

  // The overflow flag travels with out so both describe the same result.
  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [ACC_WIDTH-1:0] out_q;
      logic                 outv_q;
      logic                 outf_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_q  <= '0;
          outv_q <= 1'b0;
          outf_q <= 1'b0;
        end else if (ce) begin
          out_q  <= acc_q;
          outv_q <= accv_q;
          outf_q <= ovf_q;
        end
      end
      assign out       = out_q;
      assign out_valid = outv_q;
      assign overflow  = outf_q;
    end else begin : g_out_bypass
      assign out       = acc_q;
      assign out_valid = accv_q;
      assign overflow  = ovf_q;
    end
  endgenerate

endmodule
